// File: rtl/frame_deframer_param.sv
// Parametrised stream deframer: HDR HDR CH D0..DN-1 CRC TAIL TAIL.
// Payload words are buffered per slot while a running CRC-16 is
// computed. One packed FIFO write is issued per good frame. Bad or
// lost frames raise a one-cycle status pulse instead.

// One payload slot: cleared at frame start, loaded when its index is pushed.
module frame_deframer_slot #(
  parameter int unsigned WORD_W = 16
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic              clr,
  input  logic              ld,
  input  logic [WORD_W-1:0] din,
  output logic [WORD_W-1:0] dout
);
  logic [WORD_W-1:0] data_q, data_d;

  // Slot next-value: clear has priority over load.
  always_comb begin
    data_d = data_q;
    if (clr)     data_d = '0;
    else if (ld) data_d = din;
  end

  // Slot register.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) data_q <= '0;
    else     data_q <= data_d;
  end

  assign dout = data_q;
endmodule

module frame_deframer_param #(
  parameter int unsigned       WORD_W    = 16,
  parameter int unsigned       CH_W      = 8,
  parameter int unsigned       MAX_WORDS = 8,
  parameter logic [WORD_W-1:0] HDR_WORD  = 16'hE0E0,
  parameter logic [WORD_W-1:0] TAIL_WORD = 16'h0E0E,
  parameter logic [15:0]       CRC_POLY  = 16'h1021,
  parameter logic [15:0]       CRC_INIT  = 16'hFFFF,
  localparam int unsigned      LEN_W     = $clog2(MAX_WORDS + 1),
  localparam int unsigned      OUT_W     = LEN_W + CH_W + MAX_WORDS * WORD_W
) (
  input  logic              clk_in,
  input  logic              rst,
  input  logic [WORD_W-1:0] data_in,
  input  logic              data_valid,
  input  logic              fifo_full,
  output logic [OUT_W-1:0]  fifo_w_data,
  output logic              fifo_w_enable,
  output logic              crc_err,
  output logic              len_err,
  output logic              frame_drop
);
  localparam int unsigned CRC_W  = 16;
  localparam int unsigned STAGES = 1;  // 2-deep CRC/tail look-behind pipe

  typedef enum logic [1:0] {S_IDLE, S_HDR2, S_CHAN, S_BODY} state_t;

  // Registered per-frame outcome; exactly one field may be set per tail.
  typedef struct packed {
    logic wr;
    logic crc_err;
    logic len_err;
    logic drop;
  } resp_t;

  state_t              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [LEN_W-1:0]    n_q, n_d;
  logic [CRC_W-1:0]    crc_q, crc_d;
  logic [WORD_W-1:0]   p0_q, p0_d, p1_q, p1_d;
  logic [STAGES:0]     vld_pipe_q, vld_pipe_d;
  resp_t               resp_q, resp_d;
  logic [OUT_W-1:0]    fifo_data_q, fifo_data_d;

  logic                          slot_clr;
  logic                          slot_ld;
  logic [MAX_WORDS-1:0]          slot_sel;
  logic [MAX_WORDS-1:0][WORD_W-1:0] slot_word;
  logic [MAX_WORDS-1:0][WORD_W-1:0] payload;
  logic                          tail_hit;

  // CRC-16, MSB-first, one full word per call, no reflection.
  function automatic logic [CRC_W-1:0] crc_next(input logic [CRC_W-1:0] c,
                                                input logic [WORD_W-1:0] w);
    logic [CRC_W-1:0] r;
    logic             fb;
    r = c;
    for (int i = WORD_W - 1; i >= 0; i--) begin
      fb = r[CRC_W-1] ^ w[i];
      r  = {r[CRC_W-2:0], 1'b0};
      if (fb) r = r ^ CRC_POLY;
    end
    return r;
  endfunction

  // Payload slots; word 0 lands in the most significant slice of the output.
  for (genvar k = 0; k < MAX_WORDS; k++) begin : g_slot
    assign slot_sel[k] = slot_ld && (n_q == LEN_W'(k));
    frame_deframer_slot #(.WORD_W(WORD_W)) u_slot (
      .clk_in (clk_in),
      .rst    (rst),
      .clr    (slot_clr),
      .ld     (slot_sel[k]),
      .din    (p1_q),
      .dout   (slot_word[k])
    );
    assign payload[MAX_WORDS-1-k] = slot_word[k];
  end

  // Second tail word only counts once the pipe holds CRC + first tail.
  assign tail_hit = (data_in == TAIL_WORD) && (p0_q == TAIL_WORD) && vld_pipe_q[STAGES];

  // Frame parser: next state, pipe/CRC/count updates and commit decision.
  always_comb begin
    state_d     = state_q;
    ch_d        = ch_q;
    n_d         = n_q;
    crc_d       = crc_q;
    p0_d        = p0_q;
    p1_d        = p1_q;
    vld_pipe_d  = vld_pipe_q;
    resp_d      = '0;
    fifo_data_d = fifo_data_q;
    slot_clr    = 1'b0;
    slot_ld     = 1'b0;
    if (data_valid) begin
      case (state_q)
        S_IDLE: if (data_in == HDR_WORD) state_d = S_HDR2;
        S_HDR2: state_d = (data_in == HDR_WORD) ? S_CHAN : S_IDLE;
        S_CHAN: begin
          ch_d       = data_in[CH_W-1:0];
          vld_pipe_d = '0;
          n_d        = '0;
          crc_d      = CRC_INIT;
          slot_clr   = 1'b1;
          state_d    = S_BODY;
        end
        S_BODY: begin
          if (tail_hit) begin
            // p1 is the CRC field; payload is already complete.
            state_d = S_IDLE;
            if (n_q == '0)                    resp_d.len_err = 1'b1;
            else if (p1_q != WORD_W'(crc_q))  resp_d.crc_err = 1'b1;
            else if (fifo_full)               resp_d.drop    = 1'b1;
            else begin
              resp_d.wr   = 1'b1;
              fifo_data_d = {n_q, ch_q, payload};
            end
          end else begin
            if (vld_pipe_q[STAGES]) begin
              // p1 leaves the pipe as the next payload word.
              if (n_q == LEN_W'(MAX_WORDS)) begin
                resp_d.len_err = 1'b1;
                state_d        = S_IDLE;
              end else begin
                slot_ld = 1'b1;
                crc_d   = crc_next(crc_q, p1_q);
                n_d     = n_q + LEN_W'(1);
              end
            end
            p1_d       = p0_q;
            p0_d       = data_in;
            vld_pipe_d = {vld_pipe_q[STAGES-1:0], 1'b1};
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State, pipe and output registers.
  always_ff @(posedge clk_in or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      ch_q        <= '0;
      n_q         <= '0;
      crc_q       <= CRC_INIT;
      p0_q        <= '0;
      p1_q        <= '0;
      vld_pipe_q  <= '0;
      resp_q      <= '0;
      fifo_data_q <= '0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      n_q         <= n_d;
      crc_q       <= crc_d;
      p0_q        <= p0_d;
      p1_q        <= p1_d;
      vld_pipe_q  <= vld_pipe_d;
      resp_q      <= resp_d;
      fifo_data_q <= fifo_data_d;
    end
  end

  assign fifo_w_data   = fifo_data_q;
  assign fifo_w_enable = resp_q.wr;
  assign crc_err       = resp_q.crc_err;
  assign len_err       = resp_q.len_err;
  assign frame_drop    = resp_q.drop;
endmodule
